// File: rtl/ifetch_buf_pkg.sv
// ifetch_buf_pkg: shared CPU widths and the fetch buffer entry type
package ifetch_buf_pkg;
  localparam int CPU_AW = 6;
  localparam int CPU_DW = 32;
  typedef struct packed {
    logic [CPU_AW-1:0] pc;
    logic [CPU_DW-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_buf_if.sv
// ifetch_buf_if: PC handshake, instruction memory and decode-side signals of the fetch buffer
interface ifetch_buf_if #(
  parameter int AW = ifetch_buf_pkg::CPU_AW,
  parameter int DW = ifetch_buf_pkg::CPU_DW
);
  logic [AW-1:0] pc_i;
  logic          pc_ack;
  logic [AW-1:0] imem_addr;
  logic          imem_rd;
  logic [DW-1:0] imem_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  modport master (
    input  pc_i, imem_data, flush, out_ready,
    output pc_ack, imem_addr, imem_rd, out_valid, out_instr, out_pc
  );
  modport slave (
    output pc_i, imem_data, flush, out_ready,
    input  pc_ack, imem_addr, imem_rd, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry storage of fetched {pc, instr} with wrapping pointers and occupancy
module ifetch_fifo
  import ifetch_buf_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [PW:0]  occ
);
  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  // pointers wrap naturally at DEPTH; reset and clear empty the buffer
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      wp  <= wp + PW'(push);
      rp  <= rp + PW'(pop);
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // entry storage is deliberately left unreset
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  assign dout = mem[rp];
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push && !clr |-> pop || occ < (PW+1)'(DEPTH));
endmodule

// File: rtl/ifetch_buf.sv
// ifetch_buf: credit-based instruction fetch buffer between the PC register and decode
module ifetch_buf
  import ifetch_buf_pkg::*;
#(
  parameter int AW    = CPU_AW,
  parameter int DW    = CPU_DW,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  ifetch_buf_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0]   occ;
  logic          inflight;
  logic [AW-1:0] inflight_pc;
  logic          pop, push, issue;
  fetch_entry_t  head;
  // credits: buffered entries plus the outstanding read; the head leaving this cycle frees its slot
  always_comb begin
    bus.out_valid = rst_n && occ != '0;
    pop           = bus.out_valid && bus.out_ready && !bus.flush;
    push          = inflight && !bus.flush;
    issue         = rst_n && !bus.flush &&
                    (PW+2)'(occ) + (PW+2)'(inflight) < (PW+2)'(DEPTH) + (PW+2)'(pop);
    bus.imem_rd   = issue;
    bus.pc_ack    = issue;
    bus.imem_addr = bus.pc_i;
    bus.out_instr = head.instr;
    bus.out_pc    = head.pc;
  end
  // track the single outstanding read; a flush cancels it because issue is blocked that cycle
  always_ff @(posedge clk) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= issue;
    if (issue) inflight_pc <= bus.pc_i;
  end
  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (bus.flush),
    .push (push),
    .pop  (pop),
    .din  ('{pc: inflight_pc, instr: bus.imem_data}),
    .dout (head),
    .occ  (occ)
  );
endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: scoreboard bench driving a DEPTH=2 and a DEPTH=4 fetch buffer side by side
module tb_ifetch_buf;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, flush, out_ready;
  logic [5:0]  pc   [2];
  logic [31:0] data [2];
  logic        ack [2], rd [2], ov [2], rd_s [2], ack_s [2];
  logic [5:0]  addr [2], opc [2], addr_s [2];
  logic [31:0] oin [2];
  logic [37:0] sb [2][$];
  int          d [2];
  int          iss [2];
  int          tests = 0, fails = 0;
  ifetch_buf_if b2 ();
  ifetch_buf_if b4 ();
  assign b2.pc_i = pc[0];
  assign b2.imem_data = data[0];
  assign b2.flush = flush;
  assign b2.out_ready = out_ready;
  assign b4.pc_i = pc[1];
  assign b4.imem_data = data[1];
  assign b4.flush = flush;
  assign b4.out_ready = out_ready;
  assign ack[0] = b2.pc_ack;
  assign rd[0] = b2.imem_rd;
  assign ov[0] = b2.out_valid;
  assign addr[0] = b2.imem_addr;
  assign opc[0] = b2.out_pc;
  assign oin[0] = b2.out_instr;
  assign ack[1] = b4.pc_ack;
  assign rd[1] = b4.imem_rd;
  assign ov[1] = b4.out_valid;
  assign addr[1] = b4.imem_addr;
  assign opc[1] = b4.out_pc;
  assign oin[1] = b4.out_instr;
  ifetch_buf #(.DEPTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  ifetch_buf #(.DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  function automatic logic [31:0] mem(input logic [5:0] a);
    return {8'hC0, 2'b00, a, 8'h5A, 2'b00, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock cycle: monitor at negedge, then memory answer and PC advance after posedge
  task automatic step();
    logic [37:0] e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rd_s[k] = rd[k];
      addr_s[k] = addr[k];
      ack_s[k] = ack[k];
      if (!rst_n || flush) sb[k].delete();
      else begin
        if (ov[k] && out_ready) begin
          check($sformatf("pop_expected[%0d]", k), 64'(sb[k].size() != 0), 64'd1);
          if (sb[k].size() != 0) begin
            e = sb[k].pop_front();
            check($sformatf("out_pc[%0d]", k), 64'(opc[k]), 64'(e[37:32]));
            check($sformatf("out_instr[%0d]", k), 64'(oin[k]), 64'(e[31:0]));
          end
        end
        if (ack[k]) begin
          check($sformatf("imem_addr[%0d]", k), 64'(addr[k]), 64'(pc[k]));
          sb[k].push_back({pc[k], mem(pc[k])});
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      data[k] = rd_s[k] ? mem(addr_s[k]) : 32'd0;
      if (ack_s[k]) pc[k] = pc[k] + 6'd1;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    d[0] = 2; d[1] = 4;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    pc[0] = '0; pc[1] = '0; data[0] = '0; data[1] = '0;
    steps(2);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_valid[%0d]", k), 64'(ov[k]), 64'd0);
      check($sformatf("rst_rd[%0d]", k), 64'(rd[k]), 64'd0);
      check($sformatf("rst_ack[%0d]", k), 64'(ack[k]), 64'd0);
    end
    // streaming at full rate from reset release
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("stream_ack[%0d]", k), 64'(ack[k]), 64'd1);
        check($sformatf("stream_rd[%0d]", k), 64'(rd[k]), 64'd1);
        if (i >= 2) check($sformatf("stream_valid[%0d]", k), 64'(ov[k]), 64'd1);
      end
      step();
    end
    // decode stall from reset: issues stop once credits run out, head held
    rst_n = 1'b0; out_ready = 1'b0; pc[0] = '0; pc[1] = '0;
    step();
    rst_n = 1'b1;
    iss[0] = 0; iss[1] = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        iss[k] += int'(ack[k]);
        if (i >= 2) begin
          check($sformatf("stall_valid[%0d]", k), 64'(ov[k]), 64'd1);
          check($sformatf("stall_pc[%0d]", k), 64'(opc[k]), 64'd0);
        end
        if (i == 4) check($sformatf("stall_ack[%0d]", k), 64'(ack[k]), 64'd0);
      end
      step();
    end
    for (int k = 0; k < 2; k++) check($sformatf("stall_issues[%0d]", k), 64'(iss[k]), 64'(d[k]));
    out_ready = 1'b1;
    step();
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("resume_ack[%0d]", k), 64'(ack[k]), 64'd1);
    steps(8);
    // flush with entries buffered and a read outstanding, redirect to 0x20
    out_ready = 1'b0;
    step();
    flush = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("preflush_valid[%0d]", k), 64'(ov[k]), 64'd1);
      check($sformatf("flush_ack[%0d]", k), 64'(ack[k]), 64'd0);
    end
    step();
    flush = 1'b0; out_ready = 1'b1; pc[0] = 6'h20; pc[1] = 6'h20;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("postflush_valid[%0d]", k), 64'(ov[k]), 64'd0);
      check($sformatf("postflush_addr[%0d]", k), 64'(addr[k]), 64'h20);
      check($sformatf("postflush_rd[%0d]", k), 64'(rd[k]), 64'd1);
    end
    steps(2);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("redirect_valid[%0d]", k), 64'(ov[k]), 64'd1);
      check($sformatf("redirect_pc[%0d]", k), 64'(opc[k]), 64'h20);
    end
    steps(5);
    // fill, then push and pop around a full buffer with out_ready toggling
    out_ready = 1'b0;
    steps(6);
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("full_ack[%0d]", k), 64'(ack[k]), 64'd0);
    for (int i = 0; i < 10; i++) begin
      out_ready = (i % 2 == 0);
      step();
    end
    out_ready = 1'b1;
    steps(10);
    // reset while full with a read outstanding
    out_ready = 1'b0;
    steps(6);
    out_ready = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrst_rd[%0d]", k), 64'(rd[k]), 64'd0);
      check($sformatf("midrst_ack[%0d]", k), 64'(ack[k]), 64'd0);
    end
    step();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("afterrst_valid[%0d]", k), 64'(ov[k]), 64'd0);
      check($sformatf("afterrst_rd[%0d]", k), 64'(rd[k]), 64'd0);
    end
    step();
    rst_n = 1'b1; pc[0] = 6'h10; pc[1] = 6'h10;
    steps(2);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("release_valid[%0d]", k), 64'(ov[k]), 64'd1);
      check($sformatf("release_pc[%0d]", k), 64'(opc[k]), 64'h10);
    end
    steps(6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
